// File: rtl/izhikevich_scheduler.sv
// Time-multiplexed Izhikevich scheduler: each timestep sweeps every neuron through
// one shared dv/dw datapath, integrates v/w, applies the spike reset and writes back.
module izhikevich_scheduler #(
    parameter int           N           = 16,
    parameter int           Q           = 8,
    parameter int           NUM_NEURONS = 8,
    parameter int           IDX_W       = 3,
    parameter int           DP_LAT      = 1,
    parameter logic [N-1:0] V_TH        = 16'h004D,
    parameter logic [N-1:0] C_RESET     = 16'hFF5A,
    parameter logic [N-1:0] D_INC       = 16'h0014,
    parameter logic [N-1:0] V_INIT      = 16'hFF5A,
    parameter logic [N-1:0] W_INIT      = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IDX_W-1:0] cur_idx,
    input  logic [N-1:0]     cur_i,
    output logic [N-1:0]     dp_v,
    output logic [N-1:0]     dp_w,
    output logic [N-1:0]     dp_i,
    input  logic [N-1:0]     dp_dv,
    input  logic [N-1:0]     dp_dw,
    output logic             busy,
    output logic             done,
    output logic             spike_valid,
    output logic [IDX_W-1:0] spike_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [N-1:0]     rd_v,
    output logic [N-1:0]     rd_w
);

    localparam int CNT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DP_LAT - 1);

    if (IDX_W != $clog2(NUM_NEURONS) || Q >= N || DP_LAT < 1 || NUM_NEURONS < 2) begin : g_param_check
        $error("izhikevich_scheduler: inconsistent parameters");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] wait_cnt;
    logic [N-1:0]     res_dv;
    logic [N-1:0]     res_dw;
    logic [N-1:0]     v_mem [NUM_NEURONS];
    logic [N-1:0]     w_mem [NUM_NEURONS];
    logic [N-1:0]     v_sum;
    logic [N-1:0]     w_sum;
    logic             fire;
    logic             last;

    // Integration wraps at N bits; the threshold test sees v' before any spike reset.
    always_comb begin
        v_sum = v_mem[idx] + res_dv;
        w_sum = w_mem[idx] + res_dw;
        fire  = ($signed(v_sum) >= $signed(V_TH));
        last  = (idx == IDX_W'(NUM_NEURONS - 1));
    end

    assign rd_v = v_mem[rd_idx];
    assign rd_w = w_mem[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            wait_cnt    <= '0;
            res_dv      <= '0;
            res_dw      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
            cur_idx     <= '0;
            dp_v        <= '0;
            dp_w        <= '0;
            dp_i        <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_mem[i] <= V_INIT;
                w_mem[i] <= W_INIT;
            end
        end else begin
            done        <= 1'b0;
            spike_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_LOAD;
                        idx     <= '0;
                        cur_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                // cur_idx already points at idx here, so cur_i belongs to this neuron.
                S_LOAD: begin
                    dp_v     <= v_mem[idx];
                    dp_w     <= w_mem[idx];
                    dp_i     <= cur_i;
                    wait_cnt <= CNT_LOAD;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        res_dv <= dp_dv;
                        res_dw <= dp_dw;
                        state  <= S_WRITE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_WRITE: begin
                    if (fire) begin
                        v_mem[idx]  <= C_RESET;
                        w_mem[idx]  <= w_sum + D_INC;
                        spike_valid <= 1'b1;
                        spike_idx   <= idx;
                    end else begin
                        v_mem[idx] <= v_sum;
                        w_mem[idx] <= w_sum;
                    end
                    if (last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        idx     <= idx + 1'b1;
                        cur_idx <= idx + 1'b1;
                        state   <= S_LOAD;
                    end
                end
                S_DONE: begin
                    idx   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_izhikevich_scheduler.sv
// Self-checking bench for izhikevich_scheduler: a reference model predicts v/w and
// spike order per sweep; observed spikes/done/operands are queued and compared.
module tb_izhikevich_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  cur_idx;
    logic [15:0] cur_i;
    logic [15:0] dp_v;
    logic [15:0] dp_w;
    logic [15:0] dp_i;
    logic [15:0] dp_dv;
    logic [15:0] dp_dw;
    logic        busy;
    logic        done;
    logic        spike_valid;
    logic [2:0]  spike_idx;
    logic [2:0]  rd_idx;
    logic [15:0] rd_v;
    logic [15:0] rd_w;

    logic        dv_mode;
    logic [15:0] dv_const;
    logic [15:0] dw_const;
    logic [15:0] cur_tab [8];

    logic [15:0] mv [8];
    logic [15:0] mw [8];
    int          exp_spike_q[$];
    int          obs_spike_q[$];
    int          obs_spike_rel_q[$];
    int          sweep_done_rel;
    int          sweep_done_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    izhikevich_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cur_idx     (cur_idx),
        .cur_i       (cur_i),
        .dp_v        (dp_v),
        .dp_w        (dp_w),
        .dp_i        (dp_i),
        .dp_dv       (dp_dv),
        .dp_dw       (dp_dw),
        .busy        (busy),
        .done        (done),
        .spike_valid (spike_valid),
        .spike_idx   (spike_idx),
        .rd_idx      (rd_idx),
        .rd_v        (rd_v),
        .rd_w        (rd_w)
    );

    always #5 clk = ~clk;

    // Stand-in for the neuron datapath: either constants or dv taken from the current operand.
    assign cur_i = cur_tab[cur_idx];
    assign dp_dv = dv_mode ? dp_i : dv_const;
    assign dp_dw = dw_const;

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mv[k] = 16'hFF5A;
            mw[k] = 16'h0000;
        end
    endtask

    task automatic model_sweep();
        logic [15:0] dv;
        logic [15:0] vn;
        logic [15:0] wn;
        for (int k = 0; k < 8; k++) begin
            dv = dv_mode ? cur_tab[k] : dv_const;
            vn = mv[k] + dv;
            wn = mw[k] + dw_const;
            if ($signed(vn) >= $signed(16'sh004D)) begin
                mv[k] = 16'hFF5A;
                mw[k] = wn + 16'h0014;
                exp_spike_q.push_back(k);
            end else begin
                mv[k] = vn;
                mw[k] = wn;
            end
        end
    endtask

    // Pulses start once and logs spikes and done over a fixed 40-cycle window.
    task automatic run_sweep();
        obs_spike_q.delete();
        obs_spike_rel_q.delete();
        sweep_done_rel = -1;
        sweep_done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int rel = 1; rel <= 40; rel++) begin
            if (spike_valid) begin
                obs_spike_q.push_back(int'(spike_idx));
                obs_spike_rel_q.push_back(rel);
            end
            if (done) begin
                sweep_done_cnt++;
                if (sweep_done_rel < 0) sweep_done_rel = rel;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || spike_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: busy=%b done=%b spike_valid=%b, expected all 0", busy, done, spike_valid);
        end
        tests_run++;
        if (cur_idx !== 3'd0 || spike_idx !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idx: cur_idx=%0d spike_idx=%0d, expected 0/0", cur_idx, spike_idx);
        end
        tests_run++;
        if ({dp_v, dp_w, dp_i} !== 48'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_dp: dp_v=%h dp_w=%h dp_i=%h, expected 0", dp_v, dp_w, dp_i);
        end
        for (int k = 0; k < 8; k++) begin
            rd_idx = 3'(k);
            #1;
            tests_run++;
            if (rd_v !== mv[k] || rd_w !== mw[k]) begin
                tests_failed++;
                $display("[TB] FAIL reset_state[%0d]: v=%h w=%h, expected v=%h w=%h", k, rd_v, rd_w, mv[k], mw[k]);
            end
        end
    endtask

    task automatic test_subthreshold();
        do_reset();
        dv_mode  = 1'b0;
        dv_const = 16'h0010;
        dw_const = 16'h0001;
        model_sweep();
        run_sweep();
        tests_run++;
        if (sweep_done_rel != 25 || sweep_done_cnt != 1) begin
            tests_failed++;
            $display("[TB] FAIL sub_done: cycle=%0d pulses=%0d, expected cycle 25 pulses 1", sweep_done_rel, sweep_done_cnt);
        end
        tests_run++;
        if (obs_spike_q.size() != exp_spike_q.size()) begin
            tests_failed++;
            $display("[TB] FAIL sub_spikes: got %0d spikes, expected %0d", obs_spike_q.size(), exp_spike_q.size());
        end
        exp_spike_q.delete();
        tests_run++;
        if (cur_idx !== 3'd7) begin
            tests_failed++;
            $display("[TB] FAIL sub_cur_idx_hold: cur_idx=%0d, expected 7", cur_idx);
        end
        for (int k = 0; k < 8; k++) begin
            rd_idx = 3'(k);
            #1;
            tests_run++;
            if (rd_v !== mv[k] || rd_w !== mw[k]) begin
                tests_failed++;
                $display("[TB] FAIL sub_state[%0d]: v=%h w=%h, expected v=%h w=%h", k, rd_v, rd_w, mv[k], mw[k]);
            end
        end
    endtask

    task automatic test_spike();
        int e;
        int o;
        do_reset();
        dv_mode  = 1'b0;
        dv_const = 16'h0100;
        dw_const = 16'h0000;
        model_sweep();
        run_sweep();
        tests_run++;
        if (obs_spike_q.size() != exp_spike_q.size()) begin
            tests_failed++;
            $display("[TB] FAIL spike_count: got %0d, expected %0d", obs_spike_q.size(), exp_spike_q.size());
        end
        for (int i = 1; i < obs_spike_rel_q.size(); i++) begin
            tests_run++;
            if (obs_spike_rel_q[i] - obs_spike_rel_q[i-1] != 3) begin
                tests_failed++;
                $display("[TB] FAIL spike_spacing[%0d]: gap=%0d, expected 3", i, obs_spike_rel_q[i] - obs_spike_rel_q[i-1]);
            end
        end
        while (exp_spike_q.size() > 0 && obs_spike_q.size() > 0) begin
            e = exp_spike_q.pop_front();
            o = obs_spike_q.pop_front();
            tests_run++;
            if (o != e) begin
                tests_failed++;
                $display("[TB] FAIL spike_order: spike_idx=%0d, expected %0d", o, e);
            end
        end
        exp_spike_q.delete();
        for (int k = 0; k < 8; k++) begin
            rd_idx = 3'(k);
            #1;
            tests_run++;
            if (rd_v !== mv[k] || rd_w !== mw[k]) begin
                tests_failed++;
                $display("[TB] FAIL spike_state[%0d]: v=%h w=%h, expected v=%h w=%h", k, rd_v, rd_w, mv[k], mw[k]);
            end
        end
    endtask

    // Even neurons land exactly on V_TH, odd ones one LSB below; then the roles swap.
    task automatic test_threshold_edge();
        int e;
        int o;
        do_reset();
        dv_mode  = 1'b1;
        dw_const = 16'h0000;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 8; k++) begin
                if (pass == 0) cur_tab[k] = (k % 2 == 0) ? 16'h00F3 : 16'h00F2;
                else           cur_tab[k] = 16'h0001;
            end
            model_sweep();
            run_sweep();
            tests_run++;
            if (obs_spike_q.size() != exp_spike_q.size()) begin
                tests_failed++;
                $display("[TB] FAIL thr_count[%0d]: got %0d, expected %0d", pass, obs_spike_q.size(), exp_spike_q.size());
            end
            while (exp_spike_q.size() > 0 && obs_spike_q.size() > 0) begin
                e = exp_spike_q.pop_front();
                o = obs_spike_q.pop_front();
                tests_run++;
                if (o != e) begin
                    tests_failed++;
                    $display("[TB] FAIL thr_order[%0d]: spike_idx=%0d, expected %0d", pass, o, e);
                end
            end
            exp_spike_q.delete();
            for (int k = 0; k < 8; k++) begin
                rd_idx = 3'(k);
                #1;
                tests_run++;
                if (rd_v !== mv[k] || rd_w !== mw[k]) begin
                    tests_failed++;
                    $display("[TB] FAIL thr_state[%0d][%0d]: v=%h w=%h, expected v=%h w=%h", pass, k, rd_v, rd_w, mv[k], mw[k]);
                end
            end
        end
    endtask

    // start held for 40 cycles: one sweep at cycle 0, a second when IDLE is re-entered.
    task automatic test_back_to_back();
        int exp_dpi_q[$];
        int exp_cur_q[$];
        int done_q[$];
        int idle_cycles;
        int e;
        do_reset();
        dv_mode  = 1'b0;
        dv_const = 16'h0000;
        dw_const = 16'h0000;
        idle_cycles = 0;
        for (int k = 0; k < 8; k++) begin
            cur_tab[k] = 16'(k) << 8;
            exp_dpi_q.push_back(k << 8);
            exp_cur_q.push_back(k);
        end
        @(negedge clk);
        start = 1'b1;
        for (int rel = 1; rel <= 80; rel++) begin
            @(negedge clk);
            if (rel == 40) start = 1'b0;
            if (done) done_q.push_back(rel);
            if (rel <= 51 && !busy) idle_cycles++;
            if (rel <= 22 && (rel - 1) % 3 == 0 && exp_cur_q.size() > 0) begin
                e = exp_cur_q.pop_front();
                tests_run++;
                if (int'(cur_idx) != e) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_cur_idx@%0d: cur_idx=%0d, expected %0d", rel, cur_idx, e);
                end
            end
            if (rel >= 3 && rel <= 24 && rel % 3 == 0 && exp_dpi_q.size() > 0) begin
                e = exp_dpi_q.pop_front();
                tests_run++;
                if (int'(dp_i) != e) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_dp_i@%0d: dp_i=%h, expected %h", rel, dp_i, e);
                end
            end
        end
        tests_run++;
        if (done_q.size() != 2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_sweeps: got %0d done pulses, expected 2", done_q.size());
        end else begin
            tests_run++;
            if (done_q[0] != 25 || done_q[1] != 51) begin
                tests_failed++;
                $display("[TB] FAIL b2b_done_cycles: got %0d,%0d expected 25,51", done_q[0], done_q[1]);
            end
        end
        tests_run++;
        if (idle_cycles != 1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_idle_gap: busy low for %0d cycles, expected 1", idle_cycles);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int done_seen;
        int busy_seen;
        do_reset();
        dv_mode  = 1'b0;
        dv_const = 16'h0010;
        dw_const = 16'h0001;
        done_seen = 0;
        busy_seen = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int rel = 2; rel <= 11; rel++) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || cur_idx !== 3'd3) begin
            tests_failed++;
            $display("[TB] FAIL mid_pre: busy=%b cur_idx=%0d, expected 1/3", busy, cur_idx);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_abort: busy=%b done=%b, expected 0/0", busy, done);
        end
        for (int c = 0; c < 30; c++) begin
            if (done) done_seen++;
            if (busy) busy_seen++;
            @(negedge clk);
        end
        tests_run++;
        if (done_seen != 0 || busy_seen != 0) begin
            tests_failed++;
            $display("[TB] FAIL mid_quiet: done=%0d busy=%0d cycles, expected 0/0", done_seen, busy_seen);
        end
        for (int k = 0; k < 8; k++) begin
            mv[k] = 16'hFF5A;
            mw[k] = 16'h0000;
            rd_idx = 3'(k);
            #1;
            tests_run++;
            if (rd_v !== mv[k] || rd_w !== mw[k]) begin
                tests_failed++;
                $display("[TB] FAIL mid_state[%0d]: v=%h w=%h, expected v=%h w=%h", k, rd_v, rd_w, mv[k], mw[k]);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rd_idx   = 3'd0;
        dv_mode  = 1'b0;
        dv_const = 16'h0000;
        dw_const = 16'h0000;
        for (int k = 0; k < 8; k++) cur_tab[k] = 16'h0000;
        test_reset();
        test_subthreshold();
        test_spike();
        test_threshold_edge();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/izhikevich_scheduler.md
Name: izhikevich_scheduler

Overview:
- Time-multiplexes one shared Izhikevich update datapath (dv*step and dw*step units, Q-format signed fixed point) across NUM_NEURONS neurons.
- Holds per-neuron v/w state in an internal register file.
- On each `start` it sweeps every neuron once: present operands, wait for the datapath, integrate, apply spike reset, write back.
- Sits between the network timestep controller and the combinational neuron datapath.

Parameters:
- N, 16, total fixed-point word width (signed two's complement)
- Q, 8, fractional bits
- NUM_NEURONS, 8, neurons served per timestep (>=2)
- IDX_W, 3, index width; must equal clog2(NUM_NEURONS)
- DP_LAT, 1, cycles allowed for datapath settle before sampling results (>=1)
- V_TH, 16'h004D, spike threshold (~0.30)
- C_RESET, 16'hFF5A, post-spike v (~-0.65)
- D_INC, 16'h0014, post-spike w increment (~0.08)
- V_INIT, 16'hFF5A, v value after reset
- W_INIT, 16'h0000, w value after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin one timestep sweep; honoured only in IDLE
- cur_idx  out  IDX_W  neuron whose input current is requested
- cur_i  in  N  input current for cur_idx; sampled in LOAD
- dp_v  out  N  v operand to shared datapath
- dp_w  out  N  w operand to shared datapath
- dp_i  out  N  current operand to shared datapath
- dp_dv  in  N  datapath result dv*step
- dp_dw  in  N  datapath result dw*step
- busy  out  1  high from LOAD through DONE
- done  out  1  one-cycle pulse at end of sweep
- spike_valid  out  1  one-cycle pulse, neuron spiked
- spike_idx  out  IDX_W  index of spiking neuron, valid with spike_valid
- rd_idx  in  IDX_W  debug readback select
- rd_v  out  N  combinational v[rd_idx]
- rd_w  out  N  combinational w[rd_idx]

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous, active-high.
- Reset values:
  - state=IDLE, idx=0, all v=V_INIT, all w=W_INIT.
  - busy=0, done=0, spike_valid=0, spike_idx=0, cur_idx=0.
  - dp_v/dp_w/dp_i=0.
  - Reset mid-sweep aborts immediately; partially updated neurons are also reinitialised. No done pulse.
- FSM states: IDLE, LOAD, WAIT, WRITE, DONE.
- IDLE:
  - start=1 -> LOAD with idx=0; otherwise stay.
  - start while busy is ignored (not queued).
- LOAD (1 cycle):
  - cur_idx=idx.
  - Register dp_v=v[idx], dp_w=w[idx], dp_i=cur_i.
  - Load wait counter with DP_LAT-1. -> WAIT.
- WAIT:
  - Operands held stable.
  - Counter decrements each cycle; at 0, sample dp_dv/dp_dw into a result register. -> WRITE.
- WRITE (1 cycle):
  - Compute v'=v+dv and w'=w+dw with N-bit wrap-around (no saturation).
  - If signed v' >= V_TH: v[idx]<=C_RESET, w[idx]<=w'+D_INC (wrap), spike_valid=1, spike_idx=idx. Otherwise v[idx]<=v', w[idx]<=w'.
  - If idx==NUM_NEURONS-1 -> DONE; else idx+1 -> LOAD.
- DONE: done=1 for one cycle, idx<=0. -> IDLE.
- Latency: start seen in cycle 0; sweep ends with done in cycle NUM_NEURONS*(DP_LAT+2)+1. Defaults give 25 cycles.
- Threshold equality counts as a spike.
- The spike comparison uses the unmodified v', not the reset value.
- cur_idx holds its last value outside LOAD.
- rd_v/rd_w reflect committed state. A WRITE to the same index shows on the next cycle.
- Datapath results are only sampled at the end of WAIT. Changes on dp_dv/dp_dw at any other time have no effect.

Test Plan:
- Reset then readback: rd_idx=0..7 -> all rd_v=16'hFF5A, rd_w=16'h0000. busy=0, done=0.
- Sub-threshold sweep: dp_dv=16'h0010, dp_dw=16'h0001 constant, pulse start -> done exactly at cycle 25. All v=16'hFF6A, w=16'h0001. No spike_valid.
- Spike: dp_dv=16'h0100, dp_dw=0 -> v'=16'h005A>=V_TH for every neuron. Response:
  - 8 spike_valid pulses with spike_idx 0..7 in order, spaced 3 cycles apart.
  - All v=16'hFF5A, w=16'h0014.
- Threshold edge: preload via sweeps so v'=16'h004D exactly -> spike. v'=16'h004C -> no spike.
- Busy/start: start held high for 40 cycles -> exactly one sweep per IDLE entry. No start accepted while busy=1. cur_i sampled per cur_idx (cur_i=idx*16'h0100 observed on dp_i).
- Reset mid-sweep: assert rst in WAIT of neuron 3 -> next cycle IDLE, busy=0, no done pulse, all v=V_INIT, w=W_INIT.
